eg2000_cas_decoder: RTL
=======================

EG2000_CAS_DECODER -- requirements
Module: eg2000_cas_decoder

Interface
REQ-001 Parameter CLK_RATE, default 35467980, system clock in Hz.
REQ-002 Parameter BAUD, default 1200, tape bit-cell rate; CPP = CLK_RATE/BAUD clocks per cell.
REQ-003 clk  in  1  system clock; single clock domain.
REQ-004 reset  in  1  reset is asynchronous and active-low.
REQ-005 enable  in  1  1 = decode; 0 = hold in HUNT, discard bits.
REQ-006 tape_in  in  1  FM cassette signal; asynchronous to clk.
REQ-007 byte_ready  in  1  consumer accepts byte_data when byte_valid=1.
REQ-008 byte_data  out  8  decoded byte, MSB first on tape.
REQ-009 byte_valid  out  1  byte_data holds an unconsumed byte.
REQ-010 sync_found  out  1  0x66 sync byte located; block in progress.
REQ-011 filename  out  48  six system-tape name bytes, first byte in [47:40].
REQ-012 filename_valid  out  1  filename complete for current block.
REQ-013 byte_count  out  17  bytes delivered since sync, saturating at 17'h1FFFF.
REQ-014 block_end  out  1  one-cycle pulse on inter-block gap after sync.
REQ-015 overrun  out  1  sticky: byte lost to unconsumed predecessor.

Function
REQ-016 tape_in passes a 2-flop synchroniser; either edge of the synchronised signal is a tape edge.
REQ-017 A 17-bit saturating interval counter clears on each edge and counts clocks between edges.
REQ-018 Interval < 3*CPP/4 is SHORT; 3*CPP/4 <= interval < 3*CPP/2 is LONG; otherwise INVALID.
REQ-019 Bit slicer: LONG after a cell-start edge yields bit 0; two consecutive SHORTs yield bit 1; SHORT followed by LONG is a framing error discarding the partial cell.
REQ-020 No edge for 2*CPP clocks is GAP; GAP or INVALID returns the FSM to HUNT.
REQ-021 FSM states: HUNT, SYNC_CHECK, DATA, NAME.
REQ-022 HUNT: each bit shifts left into an 8-bit window; window == 8'h66 with >= 8 bits shifted -> SYNC_CHECK, sync_found=1, bit counter cleared.
REQ-023 SYNC_CHECK: first full byte after sync is delivered; 8'h55 -> NAME, otherwise -> DATA.
REQ-024 NAME: next six bytes delivered and shifted into filename; after sixth, filename_valid=1 and -> DATA.
REQ-025 DATA: every 8 bits deliver one byte; remain until GAP or INVALID.
REQ-026 Delivery: byte_data loads and byte_valid sets 1 clock after the eighth bit is sliced; byte_count increments in the same cycle.
REQ-027 byte_valid clears on the clock where byte_valid && byte_ready.
REQ-028 New byte arriving while byte_valid=1 and byte_ready=0: overwrite byte_data, keep byte_valid=1, set overrun.
REQ-029 Simultaneous new byte and byte_ready: old byte consumed, new byte loaded, byte_valid stays 1, no overrun.
REQ-030 Leaving sync via GAP: block_end pulses 1 cycle, sync_found=0; byte_count, filename and filename_valid hold until next sync.
REQ-031 New sync: byte_count clears, filename_valid clears; filename clears only on entering NAME.
REQ-032 GAP or INVALID before sync_found: no block_end pulse.
REQ-033 enable deassertion: FSM -> HUNT next clock, partial byte discarded, pending byte_valid kept.

Reset
REQ-034 On reset low: FSM=HUNT, counters 0, synchroniser 0, all outputs 0 (byte_data, filename, byte_count included).
REQ-035 Reset mid-byte or mid-name discards all partial state; overrun clears only on reset.

Structure
REQ-036 Shared package eg2000_tape_pkg holds CPP derivation, SHORT/LONG/GAP thresholds, and constants 8'hAA leader, 8'h66 sync, 8'h55 system-tape marker.
REQ-037 One sub-module eg2000_fm_bit_slicer: synchroniser, interval counter, classification, bit/bit_valid/gap/error outputs.
REQ-038 Decoder FSM, byte assembly, handshake and filename capture stay in the top module.

Verification
REQ-039 256 x 8'hAA, 8'h66, 8'h55, "COLOUR", 3 data bytes, ready=1 -> 10 bytes delivered, filename=48'h434F4C4F5552, filename_valid=1, byte_count=10.
REQ-040 Leader, 8'h66, 8'h01, 8'hFF, ready=1 -> bytes 8'h01, 8'hFF; filename_valid stays 0; byte_count=2.
REQ-041 Same stream, byte_ready tied 0 -> byte_data=8'hFF, byte_valid=1, overrun=1 after second byte.
REQ-042 Block followed by 3*CPP silence -> exactly one block_end pulse, sync_found=0, byte_count holds.
REQ-043 Cell timing +/-20% jitter on leader and 8'h66 8'hA5 -> byte 8'hA5 delivered, no framing error.
REQ-044 reset low mid-filename -> all outputs 0 on next edge; subsequent full block decodes correctly.

Source files
------------

// File: rtl/eg2000_tape_pkg.sv
// rtl/eg2000_tape_pkg.sv - shared EG2000 cassette constants, thresholds and decoder state type
package eg2000_tape_pkg;

    localparam logic [7:0] LEADER_BYTE = 8'hAA;
    localparam logic [7:0] SYNC_BYTE   = 8'h66;
    localparam logic [7:0] SYSTEM_MARK = 8'h55;
    localparam int         CNT_W       = 17;

    typedef enum logic [1:0] {
        HUNT       = 2'd0,
        SYNC_CHECK = 2'd1,
        DATA       = 2'd2,
        NAME       = 2'd3
    } dec_state_t;

    function automatic int cpp_of(input int clk_rate, input int baud);
        return clk_rate / baud;
    endfunction

    function automatic int short_lim(input int cpp);
        return (3 * cpp) / 4;
    endfunction

    function automatic int long_lim(input int cpp);
        return (3 * cpp) / 2;
    endfunction

    function automatic int gap_lim(input int cpp);
        return 2 * cpp;
    endfunction

endpackage

// File: rtl/eg2000_cas_decoder_if.sv
// rtl/eg2000_cas_decoder_if.sv - decoded byte handshake between decoder and consumer
interface eg2000_cas_decoder_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_data, output byte_valid, input byte_ready);
    modport slave  (input byte_data, input byte_valid, output byte_ready);
endinterface

// File: rtl/eg2000_fm_bit_slicer.sv
// rtl/eg2000_fm_bit_slicer.sv - tape synchroniser, edge interval timing and FM bit slicing
module eg2000_fm_bit_slicer
    import eg2000_tape_pkg::*;
#(
    parameter int CPP = 29556
) (
    input  logic clk,
    input  logic reset,
    input  logic tape_in,
    output logic bit_out,
    output logic bit_valid,
    output logic gap,
    output logic error
);

    localparam logic [CNT_W:0] SHORT_T = (CNT_W + 1)'(short_lim(CPP));
    localparam logic [CNT_W:0] LONG_T  = (CNT_W + 1)'(long_lim(CPP));
    localparam logic [CNT_W:0] GAP_T   = (CNT_W + 1)'(gap_lim(CPP));

    logic             sync1, sync2, sync3;
    logic             half;
    logic             tape_edge;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   ivl;

    assign tape_edge = sync2 ^ sync3;
    // cnt holds clocks since the last edge minus one, so ivl is the true edge spacing
    assign ivl       = {1'b0, cnt} + (CNT_W + 1)'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync3     <= 1'b0;
            half      <= 1'b0;
            cnt       <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            gap       <= 1'b0;
            error     <= 1'b0;
        end else begin
            sync1     <= tape_in;
            sync2     <= sync1;
            sync3     <= sync2;
            bit_valid <= 1'b0;
            gap       <= 1'b0;
            error     <= 1'b0;
            if (tape_edge) begin
                cnt <= '0;
                if (ivl < SHORT_T) begin
                    if (half) begin
                        bit_out   <= 1'b1;
                        bit_valid <= 1'b1;
                        half      <= 1'b0;
                    end else begin
                        half <= 1'b1;
                    end
                end else if (ivl < LONG_T) begin
                    // a long interval after a lone short is a broken cell; drop it
                    if (!half) begin
                        bit_out   <= 1'b0;
                        bit_valid <= 1'b1;
                    end
                    half <= 1'b0;
                end else begin
                    error <= 1'b1;
                    half  <= 1'b0;
                end
            end else begin
                if (cnt != '1) begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (ivl == GAP_T) begin
                    gap  <= 1'b1;
                    half <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/eg2000_cas_decoder.sv
// rtl/eg2000_cas_decoder.sv - EG2000 cassette decoder: sync hunt, byte delivery, filename capture
module eg2000_cas_decoder
    import eg2000_tape_pkg::*;
#(
    parameter int CLK_RATE = 35467980,
    parameter int BAUD     = 1200
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        tape_in,
    eg2000_cas_decoder_if.master        byte_if,
    output logic                        sync_found,
    output logic [47:0]                 filename,
    output logic                        filename_valid,
    output logic [16:0]                 byte_count,
    output logic                        block_end,
    output logic                        overrun
);

    localparam int CPP = cpp_of(CLK_RATE, BAUD);

    logic       sl_bit, sl_bit_valid, sl_gap, sl_err;
    dec_state_t state, state_n;
    logic [7:0] shreg, sh_next, data_q;
    logic [3:0] bit_cnt;
    logic [2:0] name_cnt;
    logic       valid_q;
    logic       clear_part, enter_sync, enter_name, name_load, byte_done, leave_gap;

    eg2000_fm_bit_slicer #(.CPP(CPP)) u_slicer (
        .clk       (clk),
        .reset     (reset),
        .tape_in   (tape_in),
        .bit_out   (sl_bit),
        .bit_valid (sl_bit_valid),
        .gap       (sl_gap),
        .error     (sl_err)
    );

    assign sh_next            = {shreg[6:0], sl_bit};
    assign byte_if.byte_data  = data_q;
    assign byte_if.byte_valid = valid_q;

    always_comb begin
        state_n    = state;
        clear_part = 1'b0;
        enter_sync = 1'b0;
        enter_name = 1'b0;
        name_load  = 1'b0;
        byte_done  = 1'b0;
        leave_gap  = 1'b0;
        if (!enable) begin
            state_n    = HUNT;
            clear_part = 1'b1;
        end else if (sl_gap || sl_err) begin
            state_n    = HUNT;
            clear_part = 1'b1;
            leave_gap  = sl_gap && sync_found;
        end else if (sl_bit_valid) begin
            unique case (state)
                HUNT: begin
                    if (sh_next == SYNC_BYTE && bit_cnt >= 4'd7) begin
                        state_n    = SYNC_CHECK;
                        enter_sync = 1'b1;
                    end
                end
                SYNC_CHECK: begin
                    if (bit_cnt == 4'd7) begin
                        byte_done = 1'b1;
                        if (sh_next == SYSTEM_MARK) begin
                            state_n    = NAME;
                            enter_name = 1'b1;
                        end else begin
                            state_n = DATA;
                        end
                    end
                end
                NAME: begin
                    if (bit_cnt == 4'd7) begin
                        byte_done = 1'b1;
                        name_load = 1'b1;
                        if (name_cnt == 3'd5) begin
                            state_n = DATA;
                        end
                    end
                end
                DATA: begin
                    if (bit_cnt == 4'd7) begin
                        byte_done = 1'b1;
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= HUNT;
            shreg          <= '0;
            bit_cnt        <= '0;
            name_cnt       <= '0;
            data_q         <= '0;
            valid_q        <= 1'b0;
            sync_found     <= 1'b0;
            filename       <= '0;
            filename_valid <= 1'b0;
            byte_count     <= '0;
            block_end      <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            state     <= state_n;
            block_end <= leave_gap;
            if (clear_part) begin
                shreg      <= '0;
                bit_cnt    <= '0;
                sync_found <= 1'b0;
            end else if (sl_bit_valid) begin
                shreg <= sh_next;
                if (enter_sync) begin
                    bit_cnt        <= '0;
                    sync_found     <= 1'b1;
                    byte_count     <= '0;
                    filename_valid <= 1'b0;
                end else if (state == HUNT) begin
                    // in HUNT the counter only proves the window is full
                    if (bit_cnt != 4'd8) begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end else begin
                    bit_cnt <= (bit_cnt == 4'd7) ? 4'd0 : bit_cnt + 4'd1;
                end
            end

            if (enter_name) begin
                filename <= '0;
                name_cnt <= '0;
            end
            if (name_load) begin
                filename <= {filename[39:0], sh_next};
                name_cnt <= name_cnt + 3'd1;
                if (name_cnt == 3'd5) begin
                    filename_valid <= 1'b1;
                end
            end

            if (byte_done) begin
                data_q  <= sh_next;
                valid_q <= 1'b1;
                if (valid_q && !byte_if.byte_ready) begin
                    overrun <= 1'b1;
                end
                if (byte_count != '1) begin
                    byte_count <= byte_count + 17'd1;
                end
            end else if (valid_q && byte_if.byte_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule
